// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, oversample default and divider calculation
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;

  // Clocks per sample tick, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    den = 64'(baud) * 64'(os);
    return 32'((64'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - sample tick divider with synchronous restart
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));
  assign tick = wrap && !restart;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 receiver with framing-error detection
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 32_000_000,
  parameter int unsigned BAUD       = 1_000_000,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] rx_dat,
  output logic       received,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: derived DIV must be at least 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
    $error("uart_rx: OVERSAMPLE must be a power of two >= 8");
  end

  uart_state_e   state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  logic [1:0]    fill_q, fill_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    win_q, win_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          received_q, received_d;
  logic          frame_err_q, frame_err_d;

  logic restart, tick, fall, maj, mid;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (i_wb_clk),
    .rst_n  (i_wb_rst_n),
    .restart(restart),
    .tick   (tick)
  );

  // Edges only count once the synchroniser holds real line history,
  // so a line held low through reset release cannot fake a start.
  assign fall = (fill_q == 2'd3) && rx_prev_q && !rx_s_q;
  assign maj  = (win_q[1] & win_q[0]) | (win_q[1] & rx_s_q) | (win_q[0] & rx_s_q);
  assign mid  = tick && (smp_q == SW'(OVERSAMPLE - 1));

  always_comb begin
    state_d     = state_q;
    sync1_d     = i_rx;
    rx_s_d      = sync1_q;
    rx_prev_d   = rx_s_q;
    fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    smp_d       = smp_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    win_d       = win_q;
    rx_dat_d    = rx_dat_q;
    received_d  = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;

    if (tick) begin
      smp_d = smp_q + SW'(1);
      win_d = {win_q[0], rx_s_q};
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          restart = 1'b1;
          smp_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick && smp_q == SW'(OVERSAMPLE / 2 - 1)) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            smp_d     = '0;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
        if (mid) begin
          if (maj) begin
            rx_dat_d   = shift_q;
            received_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      fill_q      <= 2'd0;
      smp_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      win_q       <= 2'b11;
      rx_dat_q    <= 8'h00;
      received_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      fill_q      <= fill_d;
      smp_q       <= smp_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      win_q       <= win_d;
      rx_dat_q    <= rx_dat_d;
      received_q  <= received_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_dat    = rx_dat_q;
  assign received  = received_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_DATA) || (state_q == ST_STOP) || (state_q == ST_BREAK);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with random frames and line-condition cases
`timescale 1ns/1ps
module tb_uart_rx;

  localparam realtime HALF_CLK = 15.625;
  localparam realtime BIT_NS   = 1000.0;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b0;
  logic [7:0] rx_dat;
  logic       received;
  logic       frame_err;
  logic       busy;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         tests = 0;
  int         fails = 0;
  bit         busy_seen = 1'b0;
  bit         strobe_seen = 1'b0;
  bit         prev_strobe = 1'b0;

  always #(HALF_CLK) clk = ~clk;

  uart_rx dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .i_rx      (i_rx),
    .rx_dat    (rx_dat),
    .received  (received),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input realtime bit_ns);
    i_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      #(bit_ns);
    end
    i_rx = stop;
    #(bit_ns);
  endtask

  // Reference: a frame with a high stop bit yields its byte; a low stop bit is a framing error.
  task automatic send_exp(input logic [7:0] d, input bit stop, input realtime bit_ns);
    exp_t e;
    e.err  = !stop;
    e.data = d;
    exp_q.push_back(e);
    send_frame(d, stop, bit_ns);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (received || frame_err) begin
        strobe_seen = 1'b1;
        check("strobe_exclusive", {31'd0, received && frame_err}, 0);
        check("strobe_single_cycle", {31'd0, prev_strobe}, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: received=%0b frame_err=%0b rx_dat=%0h, expected none",
                   received, frame_err, rx_dat);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind_frame_err", {31'd0, frame_err}, {31'd0, e.err});
          if (!e.err) begin
            check("rx_dat", {24'd0, rx_dat}, {24'd0, e.data});
            last_good = e.data;
          end else begin
            check("rx_dat_held", {24'd0, rx_dat}, {24'd0, last_good});
          end
        end
      end
      prev_strobe = received || frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    logic [7:0] d;
    int         gap;
    bit         bad;

    rst_n = 1'b0;
    i_rx  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_dat", {24'd0, rx_dat}, 0);
    check("reset_received", {31'd0, received}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_busy", {31'd0, busy}, 0);

    // Line held low across reset release must not start a frame.
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS * 3);
    check("low_at_release_busy", {31'd0, busy_seen}, 0);
    check("low_at_release_strobe", {31'd0, strobe_seen}, 0);
    i_rx = 1'b1;
    #(BIT_NS * 2);

    send_exp(8'h70, 1'b1, BIT_NS);
    #(BIT_NS);
    drain("single_0x70");

    send_exp(8'h2E, 1'b1, BIT_NS);
    send_exp(8'h41, 1'b1, BIT_NS);
    #(BIT_NS);
    drain("back_to_back");

    busy_seen   = 1'b0;
    strobe_seen = 1'b0;
    i_rx = 1'b0;
    repeat (10) @(posedge clk);
    i_rx = 1'b1;
    #(BIT_NS * 3);
    check("glitch_busy", {31'd0, busy_seen}, 0);
    check("glitch_strobe", {31'd0, strobe_seen}, 0);

    strobe_seen = 1'b0;
    send_exp(8'h55, 1'b0, BIT_NS);
    i_rx = 1'b0;
    #(BIT_NS * 19);
    drain("break_frame_err");
    check("break_busy_held", {31'd0, busy}, 1);
    check("break_rx_dat", {24'd0, rx_dat}, 8'h41);
    i_rx = 1'b1;
    #(BIT_NS);
    check("break_busy_released", {31'd0, busy}, 0);

    fork
      send_frame(8'h33, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 5.5);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_rx_dat", {24'd0, rx_dat}, 0);
        check("midframe_reset_busy", {31'd0, busy}, 0);
        check("midframe_reset_received", {31'd0, received}, 0);
        last_good = 8'h00;
      end
    join
    #(BIT_NS);
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS);
    send_exp(8'h37, 1'b1, BIT_NS);
    #(BIT_NS);
    drain("after_reset_0x37");

    send_exp(8'hA5, 1'b1, BIT_NS / 1.03);
    #(BIT_NS);
    drain("fast_baud_0xA5");
    send_exp(8'hA5, 1'b1, BIT_NS / 0.97);
    #(BIT_NS);
    drain("slow_baud_0xA5");

    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 3);
      send_exp(d, !bad, BIT_NS);
      if (bad) begin
        i_rx = 1'b1;
        if (gap == 0) gap = 1;
      end
      #(BIT_NS * gap);
    end
    #(BIT_NS);
    drain("random_frames");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
